fpu_wb_queue: RTL

- Writeback stage directly downstream of the FPU execution stage.
- Records destination tags at issue and pairs them in order with completions from the execution stage (fp result on `fpu_complete`, integer result on `fpu_complete_rd`).
- Presents one write request at a time to the FP or integer register-file write port using a valid/ready handshake.
- Accumulates the sticky exception flags (fflags).

---
 rtl/fpu_wb_queue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fpu_wb_queue.sv
// FPU writeback queue: pairs in-order destination tags with execution completions and
// drives FPR/GPR write handshakes. Optional macro FPU_WB_NAN_BOX_EN NaN-boxes FPR data.
module fpu_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        issue_is_int,
  output logic        issue_ready,
  input  logic [15:0] fpu_result_1,
  input  logic        fpu_complete,
  input  logic [31:0] fpu_result_rd,
  input  logic        fpu_complete_rd,
  input  logic [4:0]  S_flag,
  input  logic        IV_exception,
  output logic        fpr_wr_valid,
  output logic [4:0]  fpr_wr_rd,
  output logic [31:0] fpr_wr_data,
  input  logic        fpr_wr_ready,
  output logic        gpr_wr_valid,
  output logic [4:0]  gpr_wr_rd,
  output logic [31:0] gpr_wr_data,
  input  logic        gpr_wr_ready,
  input  logic        fflags_clr,
  output logic [4:0]  fflags,
  output logic        wb_busy,
  output logic [2:0]  err_sticky
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

`ifdef FPU_WB_NAN_BOX_EN
  localparam logic [15:0] FPR_UPPER = 16'hFFFF;
`else
  localparam logic [15:0] FPR_UPPER = 16'h0000;
`endif

  logic [4:0]    r_tag_rd  [DEPTH];
  logic          r_tag_int [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  logic          r_fpr_valid, r_gpr_valid;
  logic [4:0]    r_fpr_rd, r_gpr_rd;
  logic [31:0]   r_fpr_data, r_gpr_data;
  logic [4:0]    r_fflags;
  logic [2:0]    r_err;

  logic w_push, w_cmp, w_empty, w_pop, w_both, w_kind_mm, w_match;
  logic w_full, w_drain, w_overflow, w_load;
  logic [4:0] w_flags;

  always_comb begin
    w_push     = issue_valid & issue_ready;
    w_cmp      = fpu_complete | fpu_complete_rd;
    w_empty    = (r_count == '0);
    w_pop      = w_cmp & ~w_empty;
    w_both     = fpu_complete & fpu_complete_rd;
    w_kind_mm  = w_pop & (w_both | (r_tag_int[r_rptr] != fpu_complete_rd));
    w_match    = w_pop & ~w_kind_mm;
    w_full     = r_fpr_valid | r_gpr_valid;
    w_drain    = (r_fpr_valid & fpr_wr_ready) | (r_gpr_valid & gpr_wr_ready);
    // A held request that drains this cycle frees the slot for a same-cycle reload.
    w_overflow = w_match & w_full & ~w_drain;
    w_load     = w_match & ~w_overflow;
    w_flags    = S_flag | {IV_exception, 4'b0};
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_rd[r_wptr]  <= issue_rd;
      r_tag_int[r_wptr] <= issue_is_int;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push & ~w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop & ~w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpr_valid <= 1'b0;
      r_gpr_valid <= 1'b0;
      r_fpr_rd    <= '0;
      r_gpr_rd    <= '0;
      r_fpr_data  <= '0;
      r_gpr_data  <= '0;
    end else if (w_load) begin
      r_fpr_valid <= ~fpu_complete_rd;
      r_gpr_valid <= fpu_complete_rd;
      if (fpu_complete_rd) begin
        r_gpr_rd   <= r_tag_rd[r_rptr];
        r_gpr_data <= fpu_result_rd;
      end else begin
        r_fpr_rd   <= r_tag_rd[r_rptr];
        r_fpr_data <= {FPR_UPPER, fpu_result_1};
      end
    end else if (w_drain) begin
      r_fpr_valid <= 1'b0;
      r_gpr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fflags <= '0;
      r_err    <= '0;
    end else begin
      if (fflags_clr)  r_fflags <= '0;
      else if (w_cmp)  r_fflags <= r_fflags | w_flags;
      r_err <= r_err | {w_overflow, w_kind_mm, w_cmp & w_empty};
    end
  end

  always_comb begin
    issue_ready  = (r_count != FULL_CNT);
    fpr_wr_valid = r_fpr_valid;
    fpr_wr_rd    = r_fpr_rd;
    fpr_wr_data  = r_fpr_data;
    gpr_wr_valid = r_gpr_valid;
    gpr_wr_rd    = r_gpr_rd;
    gpr_wr_data  = r_gpr_data;
    fflags       = r_fflags;
    err_sticky   = r_err;
    wb_busy      = (r_fpr_valid & ~fpr_wr_ready) | (r_gpr_valid & ~gpr_wr_ready);
  end

endmodule
